// File: rtl/x9_pkg.sv
// Shared definitions for the X9 ALU control sequencer: opcodes, FSM states,
// instruction field positions, flag bit positions and small decode helpers.
package x9_pkg;

  localparam int INSTR_W = 9;
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 5;
  localparam int FLD_MSB = 4;
  localparam int FLD_LSB = 0;
  localparam int RS_MSB  = 2;
  localparam int RS_LSB  = 0;

  localparam int SC   = 2;
  localparam int ZERO = 1;
  localparam int PARI = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_ADDI = 4'd2,  OP_LB   = 4'd3,
    OP_SB   = 4'd4,  OP_MOVR = 4'd5,  OP_MOVI = 4'd6,  OP_NOR  = 4'd7,
    OP_XOR  = 4'd8,  OP_AND  = 4'd9,  OP_OR   = 4'd10, OP_SLL  = 4'd11,
    OP_SLR  = 4'd12, OP_EQ   = 4'd13, OP_LT   = 4'd14, OP_RXOR = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } state_e;

  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_LB) || (op == OP_SB);
  endfunction

  function automatic logic updates_sc(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) ||
           (op == OP_SLL) || (op == OP_SLR);
  endfunction

  function automatic logic uses_imm(input opcode_e op);
    return (op == OP_ADDI) || (op == OP_MOVI);
  endfunction

  // addi sign-extends the 5-bit field, movi zero-extends it.
  function automatic logic [7:0] ext_imm(input opcode_e op, input logic [4:0] fld);
    logic [7:0] v;
    v = 8'h00;
    if (op == OP_ADDI)      v = {{3{fld[4]}}, fld};
    else if (op == OP_MOVI) v = {3'b000, fld};
    return v;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Down-counter that bounds how long the sequencer waits for mem_ack.
// Reloaded while clear is high; expire flags the MEM_TO-th enabled cycle.
module mem_wait_timer #(
  parameter int MEM_TO = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = $clog2(MEM_TO + 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // needs no rst_n in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= CNT_W'(MEM_TO - 1);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = i_en && (r_count == '0);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle control sequencer for the X9 ALU: instruction handshake, decode,
// flag capture with carry feedback, bounded memory handshake and write-back.
module alu_ctrl_seq
  import x9_pkg::*;
#(
  parameter int CMD_W  = 4,
  parameter int MEM_TO = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [8:0]       instr,
  output logic             instr_ready,
  output logic [CMD_W-1:0] alu_cmd,
  output logic             alu_src_imm,
  output logic [7:0]       imm,
  output logic [2:0]       rs_addr,
  output logic             alu_sc_i,
  input  logic             alu_rslt_sc,
  input  logic             alu_zero,
  input  logic             alu_pari,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             reg_we,
  output logic [2:0]       flags,
  output logic             done,
  output logic             err
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [INSTR_W-1:0]   r_instr;
  logic [2:0]           r_flags;
  opcode_e              w_opcode;
  logic [4:0]           w_field;
  logic                 w_accept;
  logic                 w_expire;

  assign w_opcode = opcode_e'(r_instr[OPC_MSB:OPC_LSB]);
  assign w_field  = r_instr[FLD_MSB:FLD_LSB];
  assign w_accept = (r_state == IDLE) && instr_valid;

  mem_wait_timer #(
    .MEM_TO   (MEM_TO)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state != MEM),
    .i_en     (r_state == MEM),
    .o_expire (w_expire)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_instr <= instr;
      // Flags come from the ALU result of the EXEC cycle; sb produces none.
      if (r_state == EXEC) begin
        if (updates_sc(w_opcode)) r_flags[SC] <= alu_rslt_sc;
        if (w_opcode != OP_SB) begin
          r_flags[ZERO] <= alu_zero;
          r_flags[PARI] <= alu_pari;
        end
      end
    end
  end

  // NOTE: every output and next-state is defaulted first so no path through
  // the case statement can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    alu_cmd     = '0;
    alu_src_imm = 1'b0;
    imm         = 8'h00;
    rs_addr     = 3'd0;
    alu_sc_i    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    flags       = 3'b000;
    done        = 1'b0;
    err         = 1'b0;
    if (rst_n) begin
      alu_cmd     = CMD_W'(w_opcode);
      alu_src_imm = uses_imm(w_opcode);
      imm         = ext_imm(w_opcode, w_field);
      rs_addr     = r_instr[RS_MSB:RS_LSB];
      alu_sc_i    = r_flags[SC];
      flags       = r_flags;
      unique case (r_state)
        IDLE: begin
          instr_ready = 1'b1;
          if (instr_valid) w_state_nxt = EXEC;
        end
        EXEC: begin
          w_state_nxt = is_mem_op(w_opcode) ? MEM : WB;
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we  = (w_opcode == OP_SB);
          // An ack arriving in the expiry cycle still completes the op.
          if (mem_ack) begin
            w_state_nxt = WB;
          end else if (w_expire) begin
            err         = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        WB: begin
          reg_we      = (w_opcode != OP_SB);
          done        = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: cycle-accurate directed checks plus a
// scoreboard of expected retirements compared whenever done or err fires.
module tb_alu_ctrl_seq;

  localparam int MEM_TO = 15;

  typedef struct packed {
    logic       done;
    logic       reg_we;
    logic       err;
    logic [2:0] flags;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [8:0] instr = 9'h000;
  logic       alu_rslt_sc = 1'b0;
  logic       alu_zero = 1'b0;
  logic       alu_pari = 1'b0;
  logic       mem_ack = 1'b0;

  logic       instr_ready;
  logic [3:0] alu_cmd;
  logic       alu_src_imm;
  logic [7:0] imm;
  logic [2:0] rs_addr;
  logic       alu_sc_i;
  logic       mem_req;
  logic       mem_we;
  logic       reg_we;
  logic [2:0] flags;
  logic       done;
  logic       err;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [2:0] m_flags = 3'b000;

  alu_ctrl_seq #(.CMD_W(4), .MEM_TO(MEM_TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_cmd     (alu_cmd),
    .alu_src_imm (alu_src_imm),
    .imm         (imm),
    .rs_addr     (rs_addr),
    .alu_sc_i    (alu_sc_i),
    .alu_rslt_sc (alu_rslt_sc),
    .alu_zero    (alu_zero),
    .alu_pari    (alu_pari),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .reg_we      (reg_we),
    .flags       (flags),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_imm(input logic [3:0] op, input logic [4:0] fld);
    if (op == 4'd2) return {{3{fld[4]}}, fld};
    if (op == 4'd6) return {3'b000, fld};
    return 8'h00;
  endfunction

  // Scoreboard side: every retirement (done) or abort (err) pops one entry.
  always @(negedge clk) begin
    if (done === 1'b1 || err === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 32'({done, err}), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_done",   32'(done),   32'(mon_e.done));
        check("sb_reg_we", 32'(reg_we), 32'(mon_e.reg_we));
        check("sb_err",    32'(err),    32'(mon_e.err));
        check("sb_flags",  32'(flags),  32'(mon_e.flags));
      end
    end
  end

  // ack_at: MEM cycle carrying mem_ack (0 = never); rst_at: MEM cycle with
  // rst_n low (0 = none); poke_exec: offer another instruction during EXEC.
  task automatic run_op(input logic [3:0] op, input logic [4:0] fld,
                        input logic a_sc, input logic a_z, input logic a_p,
                        input int ack_at, input int rst_at, input bit poke_exec);
    exp_t e;
    bit   mem_op;
    bit   acked;
    int   waited;
    mem_op      = (op == 4'd3) || (op == 4'd4);
    alu_rslt_sc = a_sc;
    alu_zero    = a_z;
    alu_pari    = a_p;
    waited      = 0;
    do begin
      tick();
      instr_valid = 1'b1;
      instr       = {op, fld};
      sample();
      waited++;
    end while (!instr_ready && waited < 20);
    check("issue_ready", 32'(instr_ready), 32'd1);
    if (!instr_ready) begin
      instr_valid = 1'b0;
      return;
    end

    if (op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd11 || op == 4'd12)
      m_flags[2] = a_sc;
    if (op != 4'd4)
      m_flags[1:0] = {a_z, a_p};
    e.err    = mem_op && (ack_at == 0) && (rst_at == 0);
    e.done   = !e.err;
    e.reg_we = !e.err && (op != 4'd4);
    e.flags  = m_flags;
    sb_q.push_back(e);

    tick();
    instr_valid = poke_exec;
    instr       = poke_exec ? 9'h1FF : 9'h000;
    sample();
    check("exec_cmd",   32'(alu_cmd),     32'(op));
    check("exec_src",   32'(alu_src_imm), 32'(op == 4'd2 || op == 4'd6));
    check("exec_imm",   32'(imm),         32'(exp_imm(op, fld)));
    check("exec_rs",    32'(rs_addr),     32'(fld[2:0]));
    check("exec_ready", 32'(instr_ready), 32'd0);
    check("exec_done",  32'(done),        32'd0);

    acked = !mem_op;
    if (mem_op) begin
      for (int k = 1; k <= MEM_TO; k++) begin
        tick();
        instr_valid = 1'b0;
        mem_ack     = (k == ack_at);
        if (k == rst_at) rst_n = 1'b0;
        sample();
        if (k == rst_at) begin
          check("rst_done", 32'(done), 32'd0);
          tick();
          rst_n   = 1'b1;
          mem_ack = 1'b0;
          sample();
          check("post_rst_mem_req", 32'(mem_req),     32'd0);
          check("post_rst_flags",   32'(flags),       32'd0);
          check("post_rst_done",    32'(done),        32'd0);
          check("post_rst_ready",   32'(instr_ready), 32'd1);
          void'(sb_q.pop_back());
          m_flags = 3'b000;
          return;
        end
        check("mem_req",  32'(mem_req), 32'd1);
        check("mem_we",   32'(mem_we),  32'(op == 4'd4));
        check("mem_done", 32'(done),    32'd0);
        check("mem_err",  32'(err),     32'((k == MEM_TO) && (k != ack_at)));
        if (k == ack_at) begin
          acked = 1'b1;
          break;
        end
      end
    end

    tick();
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    sample();
    if (acked) begin
      check("wb_done",    32'(done),    32'd1);
      check("wb_reg_we",  32'(reg_we),  32'(op != 4'd4));
      check("wb_mem_req", 32'(mem_req), 32'd0);
      tick();
      sample();
    end
    check("idle_ready",  32'(instr_ready), 32'd1);
    check("idle_done",   32'(done),        32'd0);
    check("idle_err",    32'(err),         32'd0);
    check("idle_reg_we", 32'(reg_we),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    sample();
    check("rst_ready",   32'(instr_ready), 32'd0);
    check("rst_flags",   32'(flags),       32'd0);
    check("rst_mem_req", 32'(mem_req),     32'd0);
    check("rst_done",    32'(done),        32'd0);
    check("rst_sc_i",    32'(alu_sc_i),    32'd0);
    tick();
    rst_n = 1'b1;
    sample();
    check("ready_after_rst", 32'(instr_ready), 32'd1);

    run_op(4'd0,  5'd3,    1'b1, 1'b0, 1'b1, 0, 0, 1'b0);   // add r3
    check("add_flags", 32'(flags),    32'b101);
    check("add_sc_i",  32'(alu_sc_i), 32'd1);
    run_op(4'd2,  5'h1E,   1'b0, 1'b0, 1'b0, 0, 0, 1'b0);   // addi -2
    run_op(4'd6,  5'h1E,   1'b1, 1'b1, 1'b1, 0, 0, 1'b0);   // movi 0x1E
    run_op(4'd3,  5'd2,    1'b1, 1'b0, 1'b0, 3, 0, 1'b0);   // lb, ack on 3rd MEM cycle
    run_op(4'd4,  5'd1,    1'b1, 1'b1, 1'b1, 0, 0, 1'b0);   // sb, timeout
    check("sb_to_flags", 32'(flags), 32'b000);
    run_op(4'd8,  5'd4,    1'b1, 1'b1, 1'b0, 0, 0, 1'b1);   // xor, valid poked in EXEC
    check("xor_sc_i",  32'(alu_sc_i), 32'd0);
    check("xor_flags", 32'(flags),    32'b010);
    run_op(4'd11, 5'd6,    1'b1, 1'b0, 1'b1, 0, 0, 1'b0);   // sll updates sc
    run_op(4'd13, 5'd7,    1'b0, 1'b1, 1'b1, 0, 0, 1'b0);   // eq keeps sc
    check("eq_sc_i", 32'(alu_sc_i), 32'd1);
    run_op(4'd3,  5'd0,    1'b0, 1'b0, 1'b0, MEM_TO, 0, 1'b0); // ack in expiry cycle
    run_op(4'd3,  5'd5,    1'b1, 1'b1, 1'b1, 0, 3, 1'b0);   // reset mid-MEM
    run_op(4'd0,  5'd5,    1'b0, 1'b1, 1'b0, 0, 0, 1'b0);   // add after reset
    check("final_flags", 32'(flags), 32'b010);

    repeat (2) tick();
    sample();
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
